cheri_err_monitor: RTL and testbench

//  Parametrised CHERI exception monitor for the Sonata system, sitting beside sonata_system's cheri_err_o.

---
 rtl/cheri_err_mon_pkg.sv | 38 +++
 rtl/cheri_err_fifo.sv | 51 +++++
 rtl/cheri_err_monitor.sv | 120 ++++++++++++
 tb/tb_cheri_err_monitor.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cheri_err_mon_pkg.sv
// Shared types and defaults for the CHERI exception monitor: error-type enum,
// default widths, and a name lookup for simulation reporters.
package cheri_err_mon_pkg;

  localparam int NumCheriErr      = 9;
  localparam int CntWDefault      = 16;
  localparam int TsWDefault       = 32;
  localparam int FifoDepthDefault = 4;

  // Bit position in err_i for each exception type.
  typedef enum logic [3:0] {
    Bounds,
    Tag,
    Seal,
    PermitExecute,
    PermitLoad,
    PermitStore,
    PermitStoreCap,
    PermitStoreLocalCap,
    PermitAccSysRegs
  } cheri_err_e;

  function automatic string cheri_err_name(cheri_err_e err);
    case (err)
      Bounds:              return "Bounds";
      Tag:                 return "Tag";
      Seal:                return "Seal";
      PermitExecute:       return "PermitExecute";
      PermitLoad:          return "PermitLoad";
      PermitStore:         return "PermitStore";
      PermitStoreCap:      return "PermitStoreCap";
      PermitStoreLocalCap: return "PermitStoreLocalCap";
      PermitAccSysRegs:    return "PermitAccSysRegs";
      default:             return "Unknown";
    endcase
  endfunction

endpackage

// File: rtl/cheri_err_fifo.sv
// Synchronous show-ahead FIFO for event records. A push while full is accepted
// only when a pop happens in the same cycle.
module cheri_err_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(Depth);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and the consumer gates the head with empty_o.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/cheri_err_monitor.sv
// CHERI exception monitor: edge detection, sticky seen mask, saturating counters
// and a queue of time-stamped event records. Define CHERI_ERR_MON_TIMESTAMP_EN to build the timestamp.
module cheri_err_monitor
  import cheri_err_mon_pkg::*;
#(
  parameter int NumErr    = NumCheriErr,
  parameter int CntW      = CntWDefault,
  parameter int FifoDepth = FifoDepthDefault,
  parameter int TsW       = TsWDefault
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumErr-1:0]         err_i,
  input  logic                      clear_i,
  input  logic [$clog2(NumErr)-1:0] cnt_sel_i,
  output logic [CntW-1:0]           cnt_o,
  output logic [NumErr-1:0]         seen_o,
  output logic                      new_seen_o,
  output logic                      evt_valid_o,
  input  logic                      evt_ready_i,
  output logic [NumErr-1:0]         evt_mask_o,
  output logic [TsW-1:0]            evt_time_o,
  output logic                      overflow_o
);

  localparam int SelW = $clog2(NumErr);

`ifdef CHERI_ERR_MON_TIMESTAMP_EN
  localparam int RecW = NumErr + TsW;
`else
  localparam int RecW = NumErr;
`endif

  logic [NumErr-1:0] err_q, rise;
  logic [NumErr-1:0] seen_base, seen_d;
  logic [CntW-1:0]   cnt_q [NumErr];
  logic [CntW-1:0]   cnt_d [NumErr];
  logic [CntW-1:0]   cnt_sel_d;

  logic              rec_push, rec_pop, rec_drop;
  logic              fifo_full, fifo_empty;
  logic [RecW-1:0]   rec_wdata, rec_rdata;
  logic [NumErr-1:0] head_mask;

  assign rise = err_i & ~err_q;

  // Clear takes effect first, so a rise in the clear cycle lands on a clean slate.
  assign seen_base = clear_i ? '0 : seen_o;
  assign seen_d    = seen_base | rise;

  // NOTE: every always_comb output gets a default before any conditional
  // update, otherwise synthesis infers a latch for the unassigned paths.
  always_comb begin
    cnt_sel_d = '0;
    for (int i = 0; i < NumErr; i++) begin
      cnt_d[i] = clear_i ? '0 : cnt_q[i];
      if (rise[i] && (cnt_d[i] != '1)) cnt_d[i] = cnt_d[i] + CntW'(1);
      if (cnt_sel_i == SelW'(i)) cnt_sel_d = cnt_d[i];
    end
  end

  assign rec_push = |rise;
  assign rec_pop  = evt_valid_o && evt_ready_i;
  assign rec_drop = rec_push && fifo_full && !rec_pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q      <= '0;
      seen_o     <= '0;
      new_seen_o <= 1'b0;
      cnt_q      <= '{default: '0};
      cnt_o      <= '0;
      overflow_o <= 1'b0;
    end else begin
      err_q      <= err_i;
      seen_o     <= seen_d;
      new_seen_o <= |(rise & ~seen_base);
      cnt_q      <= cnt_d;
      // Registering the next-state value keeps a rise visible on cnt_o one cycle later.
      cnt_o      <= cnt_sel_d;
      overflow_o <= (overflow_o && !clear_i) || rec_drop;
    end
  end

`ifdef CHERI_ERR_MON_TIMESTAMP_EN
  logic [TsW-1:0] ts_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ts_q <= '0;
    else         ts_q <= ts_q + TsW'(1);
  end

  assign rec_wdata  = {rise, ts_q};
  assign head_mask  = rec_rdata[RecW-1 -: NumErr];
  assign evt_time_o = evt_valid_o ? rec_rdata[TsW-1:0] : '0;
`else
  assign rec_wdata  = rise;
  assign head_mask  = rec_rdata;
  assign evt_time_o = '0;
`endif

  cheri_err_fifo #(
    .Width (RecW),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rec_push),
    .wdata_i (rec_wdata),
    .pop_i   (rec_pop),
    .rdata_o (rec_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt_valid_o = !fifo_empty;
  // Head storage is unreset, so the mask is forced to 0 while nothing is queued.
  assign evt_mask_o  = evt_valid_o ? head_mask : '0;

endmodule

// File: tb/tb_cheri_err_monitor.sv
// Directed bench for cheri_err_monitor with a queue-based reference model
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_cheri_err_monitor;

  localparam int NumErr    = 9;
  localparam int CntW      = 4;
  localparam int FifoDepth = 4;
  localparam int TsW       = 32;
  localparam int CntMax    = 15;

`ifdef CHERI_ERR_MON_TIMESTAMP_EN
  localparam int TsOn = 1;
`else
  localparam int TsOn = 0;
`endif

  typedef struct {
    logic [NumErr-1:0] mask;
    logic [TsW-1:0]    ts;
  } rec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NumErr-1:0] err = '0;
  logic              clear = 1'b0;
  logic [3:0]        sel = '0;
  logic              ready = 1'b0;

  logic [CntW-1:0]   cnt_o;
  logic [NumErr-1:0] seen_o;
  logic              new_seen_o;
  logic              evt_valid_o;
  logic [NumErr-1:0] evt_mask_o;
  logic [TsW-1:0]    evt_time_o;
  logic              overflow_o;

  int n_total = 0;
  int n_bad   = 0;

  cheri_err_monitor #(
    .NumErr    (NumErr),
    .CntW      (CntW),
    .FifoDepth (FifoDepth),
    .TsW       (TsW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .err_i       (err),
    .clear_i     (clear),
    .cnt_sel_i   (sel),
    .cnt_o       (cnt_o),
    .seen_o      (seen_o),
    .new_seen_o  (new_seen_o),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (ready),
    .evt_mask_o  (evt_mask_o),
    .evt_time_o  (evt_time_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer counts, a set for seen types, a queue of records.
  int                m_cnt [NumErr];
  logic [NumErr-1:0] m_prev, m_seen;
  logic              m_new_seen, m_ovf;
  logic [CntW-1:0]   m_cnt_out;
  int unsigned       m_cycle;
  rec_t              m_q [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_prev = '0; m_seen = '0; m_new_seen = 1'b0; m_ovf = 1'b0;
      m_cnt_out = '0; m_cycle = 0;
      m_q.delete();
    end else begin
      logic [NumErr-1:0] r;
      bit   popping;
      int   size_before;
      rec_t rec;
      r = err & ~m_prev;
      m_prev = err;
      if (clear) begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_seen = '0;
        m_ovf  = 1'b0;
      end
      for (int i = 0; i < NumErr; i++)
        if (r[i] && m_cnt[i] < CntMax) m_cnt[i]++;
      m_new_seen = |(r & ~m_seen);
      m_seen     = m_seen | r;
      m_cnt_out  = (int'(sel) < NumErr) ? CntW'(m_cnt[sel]) : '0;
      size_before = m_q.size();
      popping = (size_before > 0) && ready;
      if (popping) void'(m_q.pop_front());
      if (|r) begin
        if (size_before < FifoDepth || popping) begin
          rec.mask = r;
          rec.ts   = TsOn ? TsW'(m_cycle) : '0;
          m_q.push_back(rec);
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_cycle++;
    end
  end

  // Observation: per-cycle model comparison, popped-record log, new_seen pulse count.
  rec_t log_q [$];
  int   ns_cnt = 0;

  always @(negedge clk) begin
    rec_t got;
    check("cnt_o", 64'(cnt_o), 64'(m_cnt_out));
    check("seen_o", 64'(seen_o), 64'(m_seen));
    check("new_seen_o", 64'(new_seen_o), 64'(m_new_seen));
    check("overflow_o", 64'(overflow_o), 64'(m_ovf));
    check("evt_valid_o", 64'(evt_valid_o), 64'(m_q.size() != 0));
    check("evt_mask_o", 64'(evt_mask_o), 64'(m_q.size() != 0 ? m_q[0].mask : '0));
    check("evt_time_o", 64'(evt_time_o), 64'(m_q.size() != 0 ? m_q[0].ts : '0));
    if (new_seen_o) ns_cnt++;
    if (evt_valid_o && ready) begin
      got.mask = evt_mask_o;
      got.ts   = evt_time_o;
      log_q.push_back(got);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset then idle
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(10);
    check("t1_valid", 64'(evt_valid_o), 64'd0);
    check("t1_seen", 64'(seen_o), 64'd0);
    check("t1_cnt", 64'(cnt_o), 64'd0);
    check("t1_ovf", 64'(overflow_o), 64'd0);
    check("t1_time", 64'(evt_time_o), 64'd0);

    // 2: err[1] sampled 0,1,1,0,1 with ready high
    sel = 4'd1; ready = 1'b1; ns_cnt = 0; log_q.delete();
    foreach (log_q[i]) log_q.delete();
    for (int i = 0; i < 5; i++) begin
      err = (i == 1 || i == 2 || i == 4) ? 9'h002 : 9'h000;
      tick(1);
    end
    err = '0;
    tick(3);
    check("t2_cnt1", 64'(cnt_o), 64'd2);
    check("t2_seen", 64'(seen_o), 64'h002);
    check("t2_new_seen_pulses", 64'(ns_cnt), 64'd1);
    check("t2_records", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      check("t2_mask0", 64'(log_q[0].mask), 64'h002);
      check("t2_mask1", 64'(log_q[1].mask), 64'h002);
      check("t2_ts_delta", 64'(log_q[1].ts - log_q[0].ts), 64'(TsOn ? 3 : 0));
    end

    // 3: two types rise in the same cycle
    sel = 4'd0; log_q.delete();
    err = 9'h011;
    tick(2);
    err = '0;
    tick(2);
    check("t3_records", 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) check("t3_mask", 64'(log_q[0].mask), 64'h011);
    check("t3_cnt0", 64'(cnt_o), 64'd1);
    sel = 4'd4;
    tick(1);
    check("t3_cnt4", 64'(cnt_o), 64'd1);
    check("t3_seen", 64'(seen_o), 64'h013);

    // 4: five rises with consumer stalled, then drain and clear
    sel = 4'd2; ready = 1'b0; log_q.delete();
    for (int i = 0; i < 5; i++) begin
      err = 9'h004; tick(1);
      err = 9'h000; tick(1);
    end
    check("t4_valid", 64'(evt_valid_o), 64'd1);
    check("t4_ovf", 64'(overflow_o), 64'd1);
    check("t4_head_mask", 64'(evt_mask_o), 64'h004);
    check("t4_cnt2", 64'(cnt_o), 64'd5);
    tick(3);
    ready = 1'b1;
    tick(6);
    check("t4_records", 64'(log_q.size()), 64'd4);
    for (int i = 0; i < log_q.size(); i++) begin
      check("t4_mask", 64'(log_q[i].mask), 64'h004);
      if (i > 0) check("t4_ts_step", 64'(log_q[i].ts - log_q[i-1].ts), 64'(TsOn ? 2 : 0));
    end
    check("t4_drained", 64'(evt_valid_o), 64'd0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("t4_ovf_cleared", 64'(overflow_o), 64'd0);
    check("t4_seen_cleared", 64'(seen_o), 64'd0);
    check("t4_cnt_cleared", 64'(cnt_o), 64'd0);

    // 5: counter saturation, out-of-range select, clear together with a rise
    sel = 4'd8;
    for (int i = 0; i < 20; i++) begin
      err = 9'h100; tick(1);
      err = 9'h000; tick(1);
    end
    check("t5_saturated", 64'(cnt_o), 64'd15);
    sel = 4'd12;
    tick(1);
    check("t5_sel_out_of_range", 64'(cnt_o), 64'd0);
    sel = 4'd8;
    err = 9'h100; clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("t5_cnt_after_clear", 64'(cnt_o), 64'd1);
    check("t5_seen_after_clear", 64'(seen_o), 64'h100);
    check("t5_new_seen", 64'(new_seen_o), 64'd1);
    err = '0;
    tick(2);

    // 6: push while full with a simultaneous pop
    sel = 4'd3; ready = 1'b0; log_q.delete();
    for (int i = 0; i < 4; i++) begin
      err = 9'h008; tick(1);
      err = 9'h000; tick(1);
    end
    check("t6_full_valid", 64'(evt_valid_o), 64'd1);
    err = 9'h008; ready = 1'b1;
    tick(1);
    ready = 1'b0; err = '0;
    tick(1);
    check("t6_no_overflow", 64'(overflow_o), 64'd0);
    ready = 1'b1;
    tick(6);
    check("t6_records", 64'(log_q.size()), 64'd5);
    if (log_q.size() == 5) begin
      check("t6_tail_mask", 64'(log_q[4].mask), 64'h008);
      check("t6_tail_ts", 64'(log_q[4].ts - log_q[0].ts), 64'(TsOn ? 8 : 0));
    end

    // Asynchronous reset in the middle of a cycle with state held
    ready = 1'b0;
    err = 9'h020;
    tick(2);
    err = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(evt_valid_o), 64'd0);
    check("rst_seen", 64'(seen_o), 64'd0);
    check("rst_cnt", 64'(cnt_o), 64'd0);
    check("rst_mask", 64'(evt_mask_o), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("post_rst_valid", 64'(evt_valid_o), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
